// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - pipelined MIPS control: decode, stage control words, hazard stall and forwarding
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   instr_d[31:0]              instruction currently in D
//   stall                      freeze PC and IF/ID, bubble into D/E
//   npcop_d, branch_d, isbeq_d, extop_d      D-stage decode (combinational on instr_d)
//   aluop_e, alusrc_e, md_start_e            E-stage control word
//   md_busy                    mult/div busy counter non-zero
//   memwrite_m                 M-stage store enable
//   regwrite_w, memtoreg_w, a3_w             W-stage write-back control
//   fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e   forwarding selects: 0 none, 1 from M, 2 from W
module pipe_ctrl_unit #(
    parameter int EN_MD    = 1,
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_d,
    output logic        stall,
    output logic [1:0]  npcop_d,
    output logic        branch_d,
    output logic        isbeq_d,
    output logic [1:0]  extop_d,
    output logic [2:0]  aluop_e,
    output logic [1:0]  alusrc_e,
    output logic [1:0]  md_start_e,
    output logic        md_busy,
    output logic        memwrite_m,
    output logic        regwrite_w,
    output logic [1:0]  memtoreg_w,
    output logic [4:0]  a3_w,
    output logic [1:0]  fwd_rs_d,
    output logic [1:0]  fwd_rt_d,
    output logic [1:0]  fwd_rs_e,
    output logic [1:0]  fwd_rt_e
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1a;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_OR   = 3'd2;
    localparam logic [2:0] ALU_LUI  = 3'd3;

    // rs/rt are carried only when the instruction actually reads them (0 otherwise),
    // so unused register fields never produce stalls or forwarding.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic       regwrite;
        logic [1:0] tnew;
        logic [2:0] aluop;
        logic [1:0] alusrc;
        logic [1:0] md;
        logic       memwrite;
        logic [1:0] memtoreg;
    } e_ctrl_t;

    typedef struct packed {
        logic [4:0] a3;
        logic       regwrite;
        logic [1:0] tnew;
        logic       memwrite;
        logic [1:0] memtoreg;
    } m_ctrl_t;

    typedef struct packed {
        logic [4:0] a3;
        logic       regwrite;
        logic [1:0] memtoreg;
    } w_ctrl_t;

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rs_f;
    logic [4:0] rt_f;
    logic [4:0] rd_f;
    logic       unused_shamt;

    e_ctrl_t    dec;
    logic [1:0] tuse_rs;
    logic [1:0] tuse_rt;
    logic       is_md_d;

    e_ctrl_t    e_q, e_d;
    m_ctrl_t    m_q, m_d;
    w_ctrl_t    w_q, w_d;
    logic [3:0] cnt_q, cnt_d;

    logic       data_stall;
    logic       md_stall;

    assign op           = instr_d[31:26];
    assign fn           = instr_d[5:0];
    assign rs_f         = instr_d[25:21];
    assign rt_f         = instr_d[20:16];
    assign rd_f         = instr_d[15:11];
    assign unused_shamt = ^instr_d[10:6];

    always_comb begin
        dec      = '0;
        tuse_rs  = 2'd0;
        tuse_rt  = 2'd0;
        is_md_d  = 1'b0;
        npcop_d  = 2'd0;
        branch_d = 1'b0;
        extop_d  = 2'd0;
        case (op)
            OP_RTYPE: begin
                case (fn)
                    FN_ADDU, FN_SUBU: begin
                        dec.rs       = rs_f;
                        dec.rt       = rt_f;
                        tuse_rs      = 2'd1;
                        tuse_rt      = 2'd1;
                        dec.a3       = rd_f;
                        dec.regwrite = 1'b1;
                        dec.tnew     = 2'd1;
                        dec.aluop    = (fn == FN_SUBU) ? ALU_SUB : ALU_ADD;
                    end
                    FN_JR: begin
                        dec.rs   = rs_f;
                        tuse_rs  = 2'd0;
                        npcop_d  = 2'd3;
                        branch_d = 1'b1;
                    end
                    FN_MULT, FN_DIV: begin
                        if (EN_MD != 0) begin
                            dec.rs  = rs_f;
                            dec.rt  = rt_f;
                            tuse_rs = 2'd1;
                            tuse_rt = 2'd1;
                            dec.md  = (fn == FN_MULT) ? 2'd1 : 2'd2;
                            is_md_d = 1'b1;
                        end
                    end
                    FN_MFHI, FN_MFLO: begin
                        if (EN_MD != 0) begin
                            dec.a3       = rd_f;
                            dec.regwrite = 1'b1;
                            dec.tnew     = 2'd1;
                            dec.memtoreg = 2'd3;
                            is_md_d      = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            OP_ORI: begin
                dec.rs       = rs_f;
                tuse_rs      = 2'd1;
                dec.a3       = rt_f;
                dec.regwrite = 1'b1;
                dec.tnew     = 2'd1;
                dec.aluop    = ALU_OR;
                dec.alusrc   = 2'd1;
            end
            OP_LW: begin
                dec.rs       = rs_f;
                tuse_rs      = 2'd1;
                dec.a3       = rt_f;
                dec.regwrite = 1'b1;
                dec.tnew     = 2'd2;
                dec.alusrc   = 2'd1;
                dec.memtoreg = 2'd1;
                extop_d      = 2'd1;
            end
            OP_SW: begin
                dec.rs       = rs_f;
                dec.rt       = rt_f;
                tuse_rs      = 2'd1;
                tuse_rt      = 2'd2;
                dec.alusrc   = 2'd1;
                dec.memwrite = 1'b1;
                extop_d      = 2'd1;
            end
            OP_BEQ: begin
                dec.rs   = rs_f;
                dec.rt   = rt_f;
                npcop_d  = 2'd1;
                branch_d = 1'b1;
                extop_d  = 2'd1;
            end
            OP_LUI: begin
                dec.a3       = rt_f;
                dec.regwrite = 1'b1;
                dec.tnew     = 2'd1;
                dec.aluop    = ALU_LUI;
                dec.alusrc   = 2'd1;
                extop_d      = 2'd2;
            end
            OP_JAL: begin
                dec.a3       = 5'd31;
                dec.regwrite = 1'b1;
                dec.tnew     = 2'd0;
                dec.memtoreg = 2'd2;
                npcop_d      = 2'd2;
                branch_d     = 1'b1;
            end
            OP_J: begin
                npcop_d  = 2'd2;
                branch_d = 1'b1;
            end
            default: ;
        endcase
    end

    assign isbeq_d = (op == OP_BEQ);

    // A producer blocks a consumer only if its result is not ready by the time the consumer needs it.
    function automatic logic raw_hazard(input logic [4:0] r, input logic [1:0] tuse,
                                        input logic [4:0] a3, input logic rw, input logic [1:0] tnew);
        return (r != 5'd0) && (r == a3) && rw && (tuse < tnew);
    endfunction

    // M wins over W because it holds the younger value of the register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] r,
                                           input logic [4:0] a3m, input logic rwm, input logic [1:0] tnewm,
                                           input logic [4:0] a3w, input logic rww);
        if (r == 5'd0) begin
            return 2'd0;
        end else if ((r == a3m) && rwm && (tnewm == 2'd0)) begin
            return 2'd1;
        end else if ((r == a3w) && rww) begin
            return 2'd2;
        end
        return 2'd0;
    endfunction

    assign data_stall = raw_hazard(dec.rs, tuse_rs, e_q.a3, e_q.regwrite, e_q.tnew)
                      | raw_hazard(dec.rt, tuse_rt, e_q.a3, e_q.regwrite, e_q.tnew)
                      | raw_hazard(dec.rs, tuse_rs, m_q.a3, m_q.regwrite, m_q.tnew)
                      | raw_hazard(dec.rt, tuse_rt, m_q.a3, m_q.regwrite, m_q.tnew);

    // An op issuing from E this cycle counts as busy even though the counter loads only at the edge.
    assign md_stall = is_md_d & (md_busy | (e_q.md != 2'd0));
    assign stall    = ~reset & (data_stall | md_stall);
    assign md_busy  = (cnt_q != 4'd0);

    assign fwd_rs_d = reset ? 2'd0 : fwd_sel(dec.rs, m_q.a3, m_q.regwrite, m_q.tnew, w_q.a3, w_q.regwrite);
    assign fwd_rt_d = reset ? 2'd0 : fwd_sel(dec.rt, m_q.a3, m_q.regwrite, m_q.tnew, w_q.a3, w_q.regwrite);
    assign fwd_rs_e = reset ? 2'd0 : fwd_sel(e_q.rs, m_q.a3, m_q.regwrite, m_q.tnew, w_q.a3, w_q.regwrite);
    assign fwd_rt_e = reset ? 2'd0 : fwd_sel(e_q.rt, m_q.a3, m_q.regwrite, m_q.tnew, w_q.a3, w_q.regwrite);

    always_comb begin
        e_d          = stall ? '0 : dec;
        m_d.a3       = e_q.a3;
        m_d.regwrite = e_q.regwrite;
        m_d.tnew     = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
        m_d.memwrite = e_q.memwrite;
        m_d.memtoreg = e_q.memtoreg;
        w_d.a3       = m_q.a3;
        w_d.regwrite = m_q.regwrite;
        w_d.memtoreg = m_q.memtoreg;
        if (e_q.md == 2'd1) begin
            cnt_d = 4'(MULT_CYC);
        end else if (e_q.md == 2'd2) begin
            cnt_d = 4'(DIV_CYC);
        end else if (cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end else begin
            cnt_d = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_q   <= '0;
            m_q   <= '0;
            w_q   <= '0;
            cnt_q <= 4'd0;
        end else begin
            e_q   <= e_d;
            m_q   <= m_d;
            w_q   <= w_d;
            cnt_q <= cnt_d;
        end
    end

    assign aluop_e    = e_q.aluop;
    assign alusrc_e   = e_q.alusrc;
    assign md_start_e = e_q.md;
    assign memwrite_m = m_q.memwrite;
    assign regwrite_w = w_q.regwrite;
    assign memtoreg_w = w_q.memtoreg;
    assign a3_w       = w_q.a3;

endmodule
